// File: rtl/puf_challenge_controller.sv
// puf_challenge_controller
// Initiator side of the ring-oscillator PUF challenge/response handshake.
// A transaction sends one challenge and waits for the PUF ready flag. It then
// either enrolls the captured response into a slot table, or verifies the
// response against the stored entry by Hamming distance.
// All outputs are registers so that nothing combinational reaches the PUF core
// or the host.
module puf_challenge_controller #(
  parameter int W         = 8,
  parameter int SLOTS     = 4,
  parameter int HD_THRESH = 2,
  parameter int TIMEOUT   = 1023,
  parameter int SW        = $clog2(SLOTS),
  parameter int HDW       = $clog2(W) + 1
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_start,
  input  logic           i_mode,
  input  logic [SW-1:0]  i_slot,
  input  logic [W-1:0]   i_challenge,
  output logic           o_busy,
  output logic           o_done,
  output logic           o_pass,
  output logic           o_err,
  output logic [HDW-1:0] o_hd,
  output logic           o_puf_rst,
  output logic           o_puf_en,
  output logic [W-1:0]   o_puf_chall,
  input  logic [W-1:0]   i_puf_response,
  input  logic           i_puf_ready
);

  // The wait counter is fixed at 10 bits. TIMEOUT must therefore fit in it.
  localparam int CW = 10;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_EVAL  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           r_state;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic             r_err;
  logic [HDW-1:0]   r_hd;
  logic             r_puf_rst;
  logic             r_puf_en;
  logic [W-1:0]     r_puf_chall;
  logic             r_mode;
  logic [SW-1:0]    r_slot;
  logic [W-1:0]     r_resp;
  logic [CW-1:0]    r_wait_cnt;
  logic [W-1:0]     r_table [SLOTS];
  logic [SLOTS-1:0] r_valid;

  logic [W-1:0]     w_diff;
  logic [HDW-1:0]   w_hd;
  logic             w_hd_ok;
  logic             w_timeout;

  // Count the set bits of a W-bit vector. The result range is 0..W.
  function automatic logic [HDW-1:0] f_popcount(input logic [W-1:0] v);
    logic [HDW-1:0] c;
    c = '0;
    for (int i = 0; i < W; i++) begin
      c = c + HDW'(v[i]);
    end
    return c;
  endfunction

  // Compare the captured response against the stored entry of the latched slot.
  assign w_diff    = r_resp ^ r_table[r_slot];
  assign w_hd      = f_popcount(w_diff);
  assign w_hd_ok   = (w_hd <= HDW'(HD_THRESH));
  assign w_timeout = (r_wait_cnt == CW'(TIMEOUT));

  // Sequence the transaction.
  // Each output register is updated on the edge that enters the state where
  // the output is specified, so the output lines up with that state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_err       <= 1'b0;
      r_hd        <= '0;
      r_puf_rst   <= 1'b0;
      r_puf_en    <= 1'b0;
      r_puf_chall <= '0;
      r_mode      <= 1'b0;
      r_slot      <= '0;
      r_resp      <= '0;
      r_wait_cnt  <= '0;
      r_valid     <= '0;
    end else begin
      r_done    <= 1'b0;
      r_puf_rst <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_mode      <= i_mode;
            r_slot      <= i_slot;
            r_puf_chall <= i_challenge;
            r_puf_rst   <= 1'b1;
            r_busy      <= 1'b1;
            r_pass      <= 1'b0;
            r_err       <= 1'b0;
            r_hd        <= '0;
            r_wait_cnt  <= '0;
            r_state     <= S_ISSUE;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_ISSUE: begin
          r_wait_cnt <= '0;
          r_puf_en   <= 1'b1;
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
          // A response on the final wait cycle still counts; ready has priority.
          if (i_puf_ready) begin
            r_resp   <= i_puf_response;
            r_puf_en <= 1'b0;
            r_state  <= S_EVAL;
          end else if (w_timeout) begin
            r_err    <= 1'b1;
            r_pass   <= 1'b0;
            r_puf_en <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_wait_cnt <= r_wait_cnt + 10'd1;
            r_state    <= S_WAIT;
          end
        end
        S_EVAL: begin
          if (!r_mode) begin
            r_table[r_slot] <= r_resp;
            r_valid[r_slot] <= 1'b1;
            r_pass          <= 1'b1;
            r_hd            <= '0;
          end else if (!r_valid[r_slot]) begin
            r_err  <= 1'b1;
            r_pass <= 1'b0;
          end else begin
            r_hd   <= w_hd;
            r_pass <= w_hd_ok;
          end
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy   <= 1'b0;
          r_puf_en <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_pass      = r_pass;
  assign o_err       = r_err;
  assign o_hd        = r_hd;
  assign o_puf_rst   = r_puf_rst;
  assign o_puf_en    = r_puf_en;
  assign o_puf_chall = r_puf_chall;

endmodule

// File: tb/tb_puf_challenge_controller.sv
// Bench for puf_challenge_controller.
// The bench drives directed and random transactions. It plays the PUF core,
// whose response latency is chosen per transaction. It keeps its own picture
// of the enrolled table, from which it predicts every result and the timing.
module tb_puf_challenge_controller;

  localparam int W   = 8;
  localparam int SL  = 4;
  localparam int HDW = 4;

  logic           i_clk = 1'b0;
  logic           i_rst;
  logic           i_start;
  logic           i_mode;
  logic [1:0]     i_slot;
  logic [W-1:0]   i_challenge;
  logic           o_busy;
  logic           o_done;
  logic           o_pass;
  logic           o_err;
  logic [HDW-1:0] o_hd;
  logic           o_puf_rst;
  logic           o_puf_en;
  logic [W-1:0]   o_puf_chall;
  logic [W-1:0]   i_puf_response;
  logic           i_puf_ready;

  int n_total = 0;
  int n_bad   = 0;

  // Reference picture of the enrolled slot table.
  logic [W-1:0] m_tbl [SL];
  logic         m_vld [SL];

  puf_challenge_controller dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_start        (i_start),
    .i_mode         (i_mode),
    .i_slot         (i_slot),
    .i_challenge    (i_challenge),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_pass         (o_pass),
    .o_err          (o_err),
    .o_hd           (o_hd),
    .o_puf_rst      (o_puf_rst),
    .o_puf_en       (o_puf_en),
    .o_puf_chall    (o_puf_chall),
    .i_puf_response (i_puf_response),
    .i_puf_ready    (i_puf_ready)
  );

  always #5 i_clk = ~i_clk;

  task automatic t_check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Step one clock and settle a little past the edge.
  task automatic t_step();
    @(posedge i_clk);
    #1;
  endtask

  // Run one transaction. A value of k >= 0 raises ready on WAIT cycle k
  // (counted from 0). A value of k < 0 means the PUF never answers.
  task automatic run_txn(input logic mode, input logic [1:0] slot, input logic [W-1:0] chall,
                         input logic [W-1:0] resp, input int k, input logic poke);
    int off;
    int en_cycles;
    int rst_cycles;
    int pulse_off;
    int exp_off;
    logic e_pass;
    logic e_err;
    logic [HDW-1:0] e_hd;
    if (k < 0) begin
      e_pass = 1'b0; e_err = 1'b1; e_hd = '0; exp_off = 2 + 1024;
    end else begin
      exp_off = 4 + k;
      if (!mode) begin
        e_pass = 1'b1; e_err = 1'b0; e_hd = '0;
      end else if (!m_vld[slot]) begin
        e_pass = 1'b0; e_err = 1'b1; e_hd = '0;
      end else begin
        e_hd   = HDW'($countones(resp ^ m_tbl[slot]));
        e_pass = (e_hd <= 4'd2);
        e_err  = 1'b0;
      end
    end
    pulse_off  = poke ? int'($urandom_range(1, 3)) : -1;
    en_cycles  = 0;
    rst_cycles = 0;
    i_mode = mode; i_slot = slot; i_challenge = chall; i_start = 1'b1;
    t_step();
    i_start = 1'b0;
    t_check("issue_busy", o_busy, 1);
    t_check("issue_chall", o_puf_chall, chall);
    t_check("issue_clear", {o_pass, o_err, o_hd}, 0);
    off = 1;
    while (1) begin
      if (o_puf_en) en_cycles++;
      if (o_puf_rst) rst_cycles++;
      if (o_done || off >= 1100) break;
      i_start = (off == pulse_off);
      if (i_start) begin
        i_mode = ~mode; i_slot = 2'($urandom); i_challenge = ~chall;
      end
      i_puf_ready    = (k >= 0) && (off == 2 + k);
      i_puf_response = i_puf_ready ? resp : W'($urandom);
      t_step();
      off++;
    end
    i_start = 1'b0; i_puf_ready = 1'b0;
    t_check("done_cycle", off, exp_off);
    t_check("result", {o_pass, o_err, o_hd}, {e_pass, e_err, e_hd});
    t_check("en_cycles", en_cycles, (k < 0) ? 1024 : k + 1);
    t_check("rst_pulses", rst_cycles, 1);
    t_check("chall_hold", o_puf_chall, chall);
    if (k >= 0 && !mode) begin
      m_tbl[slot] = resp;
      m_vld[slot] = 1'b1;
    end
    t_step();
    t_check("idle_state", {o_busy, o_done, o_puf_en}, 0);
    t_check("idle_hold", {o_pass, o_err, o_hd}, {e_pass, e_err, e_hd});
  endtask

  // Abort a transaction by reset while it sits in WAIT.
  task automatic run_abort(input logic [1:0] slot);
    int dones;
    i_mode = 1'b0; i_slot = slot; i_challenge = W'($urandom); i_start = 1'b1;
    t_step();
    i_start = 1'b0;
    for (int i = 0; i < 4; i++) t_step();
    t_check("abort_in_wait", o_puf_en, 1);
    i_rst = 1'b1;
    t_step();
    i_rst = 1'b0;
    t_check("abort_outs", {o_busy, o_done, o_pass, o_err, o_hd, o_puf_rst, o_puf_en}, 0);
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      i_puf_ready = 1'b1;
      t_step();
      if (o_done || o_busy) dones++;
    end
    i_puf_ready = 1'b0;
    t_check("abort_quiet", dones, 0);
    for (int s = 0; s < SL; s++) m_vld[s] = 1'b0;
  endtask

  initial begin
    logic [W-1:0] r;
    logic [W-1:0] mask;
    logic         md;
    logic [1:0]   sl;
    i_rst = 1'b1; i_start = 1'b0; i_mode = 1'b0; i_slot = '0; i_challenge = '0;
    i_puf_response = '0; i_puf_ready = 1'b0;
    for (int s = 0; s < SL; s++) begin
      m_vld[s] = 1'b0; m_tbl[s] = '0;
    end
    t_step();
    t_step();
    i_rst = 1'b0;
    t_check("reset_outs", {o_busy, o_done, o_pass, o_err, o_hd, o_puf_rst, o_puf_en}, 0);
    t_check("reset_chall", o_puf_chall, 0);

    // VERIFY of an unenrolled slot.
    run_txn(1'b1, 2'd0, 8'h11, 8'h00, 3, 1'b0);
    // ENROLL and verify with distance 1, then with distance 8.
    run_txn(1'b0, 2'd1, 8'hA5, 8'h3C, 5, 1'b0);
    run_txn(1'b1, 2'd1, 8'hA5, 8'h3D, 2, 1'b0);
    run_txn(1'b1, 2'd1, 8'hA5, 8'hC3, 0, 1'b0);
    // Distances at the pass threshold and just above it.
    run_txn(1'b1, 2'd1, 8'h5A, 8'h3C ^ 8'h81, 1, 1'b0);
    run_txn(1'b1, 2'd1, 8'h5A, 8'h3C ^ 8'h83, 1, 1'b0);
    // A timed-out ENROLL leaves the slot unenrolled.
    run_txn(1'b0, 2'd2, 8'h77, 8'h00, -1, 1'b0);
    run_txn(1'b1, 2'd2, 8'h77, 8'h00, 1, 1'b0);
    // Ready on the final WAIT cycle wins over the timeout.
    run_txn(1'b0, 2'd3, 8'h42, 8'h9E, 1023, 1'b0);
    run_txn(1'b1, 2'd3, 8'h42, 8'h9E, 4, 1'b0);
    // A start while busy is ignored.
    run_txn(1'b1, 2'd1, 8'h10, 8'h3C, 3, 1'b1);
    // A reset mid-transaction clears the valid bits.
    run_abort(2'd0);
    run_txn(1'b1, 2'd1, 8'h20, 8'h3C, 2, 1'b0);

    for (int n = 0; n < 40; n++) begin
      md = 1'($urandom);
      sl = 2'($urandom);
      r  = W'($urandom);
      if (md && m_vld[sl] && ($urandom_range(0, 3) != 0)) begin
        mask = '0;
        for (int b = 0; b < int'($urandom_range(0, 4)); b++) mask[$urandom_range(0, W - 1)] = 1'b1;
        r = m_tbl[sl] ^ mask;
      end
      run_txn(md, sl, W'($urandom), r, int'($urandom_range(0, 20)), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
